// File: rtl/bigreg_assembler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bigreg_assembler_pkg
// Description : Shared register-map constants and big-register assembler types.
// Revision    : 1.0 - initial release
// ============================================================================
package bigreg_assembler_pkg;

    localparam int MEM_SIZE      = 256;
    localparam int WD_DATA_WIDTH = 16;
    localparam int MM_ID_WIDTH   = $clog2(MEM_SIZE);

    // Per-big-register map: first data id, sample count, valid-entry id
    localparam int SEEDS_BASE_ID  = 1;
    localparam int SEEDS_SAMPLES  = 16;
    localparam int SEEDS_VALID_ID = SEEDS_BASE_ID + SEEDS_SAMPLES;

    localparam int CHMUX_BASE_ID  = 30;
    localparam int CHMUX_SAMPLES  = 2;
    localparam int CHMUX_VALID_ID = CHMUX_BASE_ID + CHMUX_SAMPLES;

    localparam int SDCFG_BASE_ID  = 33;
    localparam int SDCFG_SAMPLES  = 16;
    localparam int SDCFG_VALID_ID = SDCFG_BASE_ID + SDCFG_SAMPLES;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PRESENT = 2'd1,
        CLEAR   = 2'd2
    } bigreg_state_t;

endpackage
`default_nettype wire

// File: rtl/bigreg_assembler.sv
`default_nettype none
// ============================================================================
// Module      : bigreg_assembler
// Description : Collects a group of register-file writes into one wide word,
//               presents it with valid/ready, then clears the group freshbits.
// Revision    : 1.0 - initial release
// ============================================================================
module bigreg_assembler
    import bigreg_assembler_pkg::*;
#(
    parameter int BASE_ID    = 33,
    parameter int SAMPLES    = 16,
    parameter int DATA_WIDTH = WD_DATA_WIDTH,
    parameter int ID_WIDTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [ID_WIDTH-1:0]           wr_id,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic [SAMPLES*DATA_WIDTH-1:0] big_data,
    output logic                          big_valid,
    input  logic                          big_ready,
    output logic                          clr_en,
    output logic [ID_WIDTH-1:0]           clr_id,
    output logic                          err,
    output logic                          drop
);

    localparam int                  CNT_W      = $clog2(SAMPLES + 1);
    localparam logic [ID_WIDTH-1:0] c_BASE_ID  = ID_WIDTH'(BASE_ID);
    localparam logic [ID_WIDTH-1:0] c_VALID_ID = ID_WIDTH'(BASE_ID + SAMPLES);
    localparam logic [CNT_W-1:0]    c_LAST_CNT = CNT_W'(SAMPLES);

    if (BASE_ID + SAMPLES >= 2**ID_WIDTH) begin : g_bad_range
        $error("bigreg_assembler: BASE_ID+SAMPLES does not fit in ID_WIDTH bits");
    end

    bigreg_state_t                 r_state;
    bigreg_state_t                 w_state_nxt;
    logic [SAMPLES*DATA_WIDTH-1:0] r_shadow;
    logic [SAMPLES-1:0]            r_mask;
    logic [CNT_W-1:0]              r_cnt;
    logic [SAMPLES*DATA_WIDTH-1:0] r_big_data;
    logic                          r_big_valid;
    logic                          r_err;
    logic                          r_drop;

    logic [ID_WIDTH-1:0] w_slot;
    logic                w_is_data;
    logic                w_is_valid;
    logic                w_in_range;
    logic                w_capture;
    logic                w_present;
    logic                w_err;
    logic                w_drop;
    logic                w_clear_done;

    assign w_slot     = wr_id - c_BASE_ID;
    assign w_is_data  = wr_en && (wr_id >= c_BASE_ID) && (wr_id < c_VALID_ID);
    assign w_is_valid = wr_en && (wr_id == c_VALID_ID);
    assign w_in_range = w_is_data || w_is_valid;

    always_comb begin
        w_state_nxt  = r_state;
        w_capture    = 1'b0;
        w_present    = 1'b0;
        w_err        = 1'b0;
        w_drop       = 1'b0;
        w_clear_done = 1'b0;
        case (r_state)
            COLLECT: begin
                if (w_is_data) begin
                    w_capture = 1'b1;
                end else if (w_is_valid) begin
                    if (&r_mask) begin
                        w_present   = 1'b1;
                        w_state_nxt = PRESENT;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = CLEAR;
                    end
                end
            end
            PRESENT: begin
                w_drop = w_in_range;
                if (r_big_valid && big_ready) begin
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                w_drop = w_in_range;
                if (r_cnt == c_LAST_CNT) begin
                    w_clear_done = 1'b1;
                    w_state_nxt  = COLLECT;
                end
            end
            default: begin
                w_state_nxt = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow    <= '0;
            r_mask      <= '0;
            r_cnt       <= '0;
            r_big_data  <= '0;
            r_big_valid <= 1'b0;
            r_err       <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_err  <= w_err;
            r_drop <= w_drop;

            // Shadow contents survive an aborted group; only the mask restarts
            if (w_err || w_clear_done) begin
                r_mask <= '0;
            end
            if (w_capture) begin
                for (int k = 0; k < SAMPLES; k++) begin
                    if (w_slot == ID_WIDTH'(k)) begin
                        r_shadow[k*DATA_WIDTH +: DATA_WIDTH] <= wr_data;
                        r_mask[k]                            <= 1'b1;
                    end
                end
            end

            if (w_present) begin
                r_big_data  <= r_shadow;
                r_big_valid <= 1'b1;
            end else if (r_state == PRESENT && big_ready) begin
                r_big_valid <= 1'b0;
            end

            if (r_state == CLEAR) begin
                r_cnt <= w_clear_done ? '0 : r_cnt + 1'b1;
            end
        end
    end

    assign big_data  = r_big_data;
    assign big_valid = r_big_valid;
    assign err       = r_err;
    assign drop      = r_drop;
    assign clr_en    = (r_state == CLEAR);
    assign clr_id    = clr_en ? (c_BASE_ID + ID_WIDTH'(r_cnt)) : '0;

endmodule
`default_nettype wire

// File: tb/tb_bigreg_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_bigreg_assembler
// Description : Self-checking bench for channel-mux and seed assembler instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bigreg_assembler;
    import bigreg_assembler_pkg::*;

    logic clk = 1'b0;
    logic rst;

    logic        a_wr_en;
    logic [7:0]  a_wr_id;
    logic [15:0] a_wr_data;
    logic [31:0] a_big_data;
    logic        a_big_valid;
    logic        a_big_ready;
    logic        a_clr_en;
    logic [7:0]  a_clr_id;
    logic        a_err;
    logic        a_drop;

    logic         b_wr_en;
    logic [7:0]   b_wr_id;
    logic [15:0]  b_wr_data;
    logic [255:0] b_big_data;
    logic         b_big_valid;
    logic         b_big_ready;
    logic         b_clr_en;
    logic [7:0]   b_clr_id;
    logic         b_err;
    logic         b_drop;

    int checks = 0;
    int errors = 0;
    int a_err_cnt = 0;
    int a_drop_cnt = 0;
    int b_drop_cnt = 0;

    logic [31:0] exp_q[$];
    logic [7:0]  clr_q[$];
    logic [31:0] exp_word = '0;
    logic [7:0]  exp_clr;
    logic        a_prev_valid = 1'b0;

    always #5 clk = ~clk;

    bigreg_assembler #(
        .BASE_ID   (CHMUX_BASE_ID),
        .SAMPLES   (CHMUX_SAMPLES),
        .DATA_WIDTH(16),
        .ID_WIDTH  (8)
    ) dut_a (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (a_wr_en),
        .wr_id    (a_wr_id),
        .wr_data  (a_wr_data),
        .big_data (a_big_data),
        .big_valid(a_big_valid),
        .big_ready(a_big_ready),
        .clr_en   (a_clr_en),
        .clr_id   (a_clr_id),
        .err      (a_err),
        .drop     (a_drop)
    );

    bigreg_assembler #(
        .BASE_ID   (SEEDS_BASE_ID),
        .SAMPLES   (SEEDS_SAMPLES),
        .DATA_WIDTH(16),
        .ID_WIDTH  (8)
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (b_wr_en),
        .wr_id    (b_wr_id),
        .wr_data  (b_wr_data),
        .big_data (b_big_data),
        .big_valid(b_big_valid),
        .big_ready(b_big_ready),
        .clr_en   (b_clr_en),
        .clr_id   (b_clr_id),
        .err      (b_err),
        .drop     (b_drop)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_a(input logic [7:0] id, input logic [15:0] d);
        a_wr_en = 1'b1; a_wr_id = id; a_wr_data = d;
        @(posedge clk); #1;
        a_wr_en = 1'b0; a_wr_id = '0; a_wr_data = '0;
    endtask

    task automatic wr_b(input logic [7:0] id, input logic [15:0] d);
        b_wr_en = 1'b1; b_wr_id = id; b_wr_data = d;
        @(posedge clk); #1;
        b_wr_en = 1'b0; b_wr_id = '0; b_wr_data = '0;
    endtask

    task automatic push_clr_a();
        clr_q.push_back(8'd30);
        clr_q.push_back(8'd31);
        clr_q.push_back(8'd32);
    endtask

    // Full group on the channel-mux instance with the consumer always ready
    task automatic group_a(input string tag, input logic [15:0] d0, input logic [15:0] d1);
        exp_q.push_back({d1, d0});
        push_clr_a();
        a_big_ready = 1'b1;
        wr_a(8'd30, d0);
        wr_a(8'd31, d1);
        wr_a(8'd32, 16'h0001);
        @(negedge clk);
        chk({tag, "_valid"}, a_big_valid, 1);
        @(negedge clk);
        chk({tag, "_clr_start"}, a_clr_en, 1);
        chk({tag, "_valid_low"}, a_big_valid, 0);
        repeat (3) @(negedge clk);
        chk({tag, "_clr_end"}, a_clr_en, 0);
    endtask

    // Scoreboard: pop expected word on each new valid, expected id on each clear cycle
    always @(negedge clk) begin
        if (a_err)  a_err_cnt++;
        if (a_drop) a_drop_cnt++;
        if (b_drop) b_drop_cnt++;
        if (a_big_valid) begin
            if (!a_prev_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $error("FAIL word_unexpected: observed %0h expected none", a_big_data);
                end else begin
                    exp_word = exp_q.pop_front();
                end
            end
            chk("a_word", a_big_data, exp_word);
        end
        a_prev_valid = a_big_valid;
        if (a_clr_en) begin
            if (clr_q.size() == 0) begin
                checks++; errors++;
                $error("FAIL clr_unexpected: observed %0h expected none", a_clr_id);
            end else begin
                exp_clr = clr_q.pop_front();
                chk("a_clr_id", a_clr_id, exp_clr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_wr_en = 1'b0; a_wr_id = '0; a_wr_data = '0; a_big_ready = 1'b0;
        b_wr_en = 1'b0; b_wr_id = '0; b_wr_data = '0; b_big_ready = 1'b0;

        @(negedge clk);
        chk("rst_a_valid", a_big_valid, 0);
        chk("rst_a_data",  a_big_data,  0);
        chk("rst_a_clr",   a_clr_en,    0);
        chk("rst_a_err",   a_err,       0);
        chk("rst_a_drop",  a_drop,      0);
        chk("rst_b_valid", b_big_valid, 0);
        chk("rst_b_clr",   b_clr_en,    0);
        @(negedge clk);
        rst = 1'b0;

        // Basic group
        group_a("t1", 16'h3210, 16'h7654);

        // Incomplete group: error pulse, clear sequence, no word
        push_clr_a();
        wr_a(8'd30, 16'hAAAA);
        wr_a(8'd32, 16'h0001);
        @(negedge clk);
        chk("t2_err",     a_err,       1);
        chk("t2_valid",   a_big_valid, 0);
        chk("t2_clr",     a_clr_en,    1);
        @(negedge clk);
        chk("t2_err_once", a_err, 0);
        repeat (2) @(negedge clk);
        chk("t2_clr_end", a_clr_en, 0);

        // Backpressure
        a_big_ready = 1'b0;
        exp_q.push_back(32'hCAFEBEEF);
        push_clr_a();
        wr_a(8'd30, 16'hBEEF);
        wr_a(8'd31, 16'hCAFE);
        wr_a(8'd32, 16'h0001);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", a_big_valid, 1);
        end
        a_big_ready = 1'b1;
        @(posedge clk); #1;
        a_big_ready = 1'b0;
        @(negedge clk);
        chk("t3_valid_low", a_big_valid, 0);
        chk("t3_clr_start", a_clr_en,    1);
        repeat (3) @(negedge clk);
        chk("t3_clr_end", a_clr_en, 0);

        // Busy drops, including a write coincident with the handshake
        a_big_ready = 1'b0;
        exp_q.push_back(32'h03040102);
        push_clr_a();
        wr_a(8'd30, 16'h0102);
        wr_a(8'd31, 16'h0304);
        wr_a(8'd32, 16'h0001);
        @(negedge clk);
        chk("t4_valid", a_big_valid, 1);
        wr_a(8'd31, 16'h1111);
        @(negedge clk);
        chk("t4_drop",       a_drop,      1);
        chk("t4_valid_held", a_big_valid, 1);
        wr_a(8'd40, 16'h0000);
        @(negedge clk);
        chk("t4_oor_nodrop", a_drop, 0);
        a_big_ready = 1'b1;
        wr_a(8'd30, 16'h2222);
        a_big_ready = 1'b0;
        @(negedge clk);
        chk("t4_hs_drop",  a_drop,      1);
        chk("t4_hs_valid", a_big_valid, 0);
        chk("t4_hs_clr",   a_clr_en,    1);
        repeat (3) @(negedge clk);
        chk("t4_clr_end", a_clr_en, 0);
        group_a("t4b", 16'h5555, 16'h6666);

        // Reset in the middle of the clear sequence
        a_big_ready = 1'b1;
        exp_q.push_back(32'h56781234);
        clr_q.push_back(8'd30);
        clr_q.push_back(8'd31);
        wr_a(8'd30, 16'h1234);
        wr_a(8'd31, 16'h5678);
        wr_a(8'd32, 16'h0001);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_clr",   a_clr_en,    0);
        chk("t5_rst_valid", a_big_valid, 0);
        chk("t5_rst_data",  a_big_data,  0);
        @(negedge clk);
        rst = 1'b0;
        group_a("t5b", 16'h9ABC, 16'hDEF0);

        // Seed instance: 16 slots plus an out-of-range write
        b_big_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            wr_b(8'(k), 16'(k - 1));
        end
        wr_b(8'd50, 16'h1234);
        @(negedge clk);
        chk("t6_oor_nodrop", b_drop, 0);
        wr_b(8'd17, 16'h0001);
        @(negedge clk);
        chk("t6_valid", b_big_valid, 1);
        for (int k = 0; k < 16; k++) begin
            chk("t6_slot", b_big_data[k*16 +: 16], 64'(k));
        end
        @(negedge clk);
        chk("t6_clr_first_en", b_clr_en, 1);
        chk("t6_clr_first_id", b_clr_id, 1);
        repeat (16) @(negedge clk);
        chk("t6_clr_last_en", b_clr_en, 1);
        chk("t6_clr_last_id", b_clr_id, 17);
        @(negedge clk);
        chk("t6_clr_end", b_clr_en, 0);

        @(negedge clk);
        chk("end_a_err_count",  a_err_cnt,    1);
        chk("end_a_drop_count", a_drop_cnt,   2);
        chk("end_b_drop_count", b_drop_cnt,   0);
        chk("end_word_queue",   exp_q.size(), 0);
        chk("end_clr_queue",    clr_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
